// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths, register address type, arbiter priority pointer and the x0 constant
package regfile_pkg;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 5;
  typedef logic [AWIDTH-1:0] reg_addr_t;
  typedef enum logic {PRI_EX, PRI_MEM} pri_e;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_arbiter_bypass.sv
// rf_bypass_mux: one read port; forwards the in-flight write (we/wa/wd) when wa matches ra under REGFILE_WB_ARB_BYPASS_EN, else rd = rf_rd
module rf_bypass_mux #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              we,
  input  logic [AWIDTH-1:0] wa,
  input  logic [DWIDTH-1:0] wd,
  input  logic [AWIDTH-1:0] ra,
  input  logic [DWIDTH-1:0] rf_rd,
  output logic [DWIDTH-1:0] rd
);
`ifdef REGFILE_WB_ARB_BYPASS_EN
  assign rd = (we && wa == ra) ? wd : rf_rd;
`else
  logic unused_bypass;
  assign unused_bypass = ^{we, wa, wd, ra};
  assign rd = rf_rd;
`endif
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin EX/MEM writeback arbiter (valid/ready) into a registered rf_we/rf_wa/rf_wd write stage, x0 writes suppressed, rd1/rd2 bypass under REGFILE_WB_ARB_BYPASS_EN
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DWIDTH = regfile_pkg::DWIDTH,
  parameter int AWIDTH = regfile_pkg::AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [AWIDTH-1:0] ex_addr,
  input  logic [DWIDTH-1:0] ex_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_data,
  output logic              rf_we,
  output logic [AWIDTH-1:0] rf_wa,
  output logic [DWIDTH-1:0] rf_wd,
  input  logic [AWIDTH-1:0] ra1,
  input  logic [AWIDTH-1:0] ra2,
  input  logic [DWIDTH-1:0] rf_rd1,
  input  logic [DWIDTH-1:0] rf_rd2,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2
);
  pri_e              pri, pri_nxt;
  logic              go, gnt;
  logic [AWIDTH-1:0] g_addr;
  logic [DWIDTH-1:0] g_data;
  always_comb begin
    go        = !rst && !stall;
    ex_ready  = go && ex_valid && (!mem_valid || pri == PRI_EX);
    mem_ready = go && mem_valid && (!ex_valid || pri == PRI_MEM);
    gnt       = ex_ready || mem_ready;
    g_addr    = ex_ready ? ex_addr : mem_addr;
    g_data    = ex_ready ? ex_data : mem_data;
    pri_nxt   = ex_ready ? PRI_MEM : mem_ready ? PRI_EX : pri;
  end
  always_ff @(posedge clk)
    pri <= rst ? PRI_EX : pri_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= gnt && g_addr != AWIDTH'(REG_ZERO);
      if (gnt) begin
        rf_wa <= g_addr;
        rf_wd <= g_data;
      end
    end
  end
  rf_bypass_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_byp1 (
    .we(rf_we), .wa(rf_wa), .wd(rf_wd), .ra(ra1), .rf_rd(rf_rd1), .rd(rd1)
  );
  rf_bypass_mux #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_byp2 (
    .we(rf_we), .wa(rf_wa), .wd(rf_wd), .ra(ra2), .rf_rd(rf_rd2), .rd(rd2)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: table-driven vectors plus hand sequences for reset, x0, stall, bypass and mid-write reset
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 1'b0;
  logic          rst, stall, ex_valid, mem_valid, ex_ready, mem_ready, rf_we;
  logic [AW-1:0] ex_addr, mem_addr, rf_wa, ra1, ra2;
  logic [DW-1:0] ex_data, mem_data, rf_wd, rf_rd1, rf_rd2, rd1, rd2;
  logic [DW-1:0] regs [32] = '{default: '0};
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (rf_we && !rst) regs[rf_wa] <= rf_wd;
  assign rf_rd1 = regs[ra1];
  assign rf_rd2 = regs[ra2];
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1(rd1), .rd2(rd2)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic          st;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          mv;
    logic [AW-1:0] ma;
    logic [DW-1:0] md;
    logic          xr;
    logic          mr;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } vec_t;
  vec_t tbl [17];
  logic [DW-1:0] byp_exp;
  initial begin
    tbl[0]  = '{0, 1, 5'd1, 32'h1, 0, 5'd0, 32'h0,    1, 0, 1, 5'd1, 32'h1};
    tbl[1]  = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,    0, 0, 0, 5'd1, 32'h1};
    tbl[2]  = '{0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF, 0, 1, 0, 5'd0, 32'hFFFF};
    tbl[3]  = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    1, 0, 1, 5'd2, 32'hA};
    tbl[4]  = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 1, 1, 5'd3, 32'hB};
    tbl[5]  = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    1, 0, 1, 5'd2, 32'hA};
    tbl[6]  = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 1, 1, 5'd3, 32'hB};
    tbl[7]  = '{1, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 0, 0, 5'd3, 32'hB};
    tbl[8]  = '{1, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 0, 0, 5'd3, 32'hB};
    tbl[9]  = '{1, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 0, 0, 5'd3, 32'hB};
    tbl[10] = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    1, 0, 1, 5'd2, 32'hA};
    tbl[11] = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 1, 1, 5'd3, 32'hB};
    tbl[12] = '{0, 0, 5'd0, 32'h0, 1, 5'd6, 32'h66,   0, 1, 1, 5'd6, 32'h66};
    tbl[13] = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    1, 0, 1, 5'd2, 32'hA};
    tbl[14] = '{0, 1, 5'd2, 32'hA, 0, 5'd0, 32'h0,    1, 0, 1, 5'd2, 32'hA};
    tbl[15] = '{0, 1, 5'd2, 32'hA, 1, 5'd3, 32'hB,    0, 1, 1, 5'd3, 32'hB};
    tbl[16] = '{0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,    0, 0, 0, 5'd3, 32'hB};
    rst = 1; stall = 0; ra1 = 0; ra2 = 0;
    ex_valid = 1; ex_addr = 5'd1; ex_data = 32'h1;
    mem_valid = 1; mem_addr = 5'd3; mem_data = 32'hB;
    #1;
    chk("rst ex_ready", ex_ready, 0);
    chk("rst mem_ready", mem_ready, 0);
    tick();
    tick();
    chk("rst rf_we", rf_we, 0);
    chk("rst rf_wa", rf_wa, 0);
    chk("rst rf_wd", rf_wd, 0);
    rst = 0;
    for (int i = 0; i < 17; i++) begin
      stall = tbl[i].st;
      ex_valid = tbl[i].ev; ex_addr = tbl[i].ea; ex_data = tbl[i].ed;
      mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      #1;
      chk($sformatf("v%0d ex_ready", i), ex_ready, tbl[i].xr);
      chk($sformatf("v%0d mem_ready", i), mem_ready, tbl[i].mr);
      tick();
      chk($sformatf("v%0d rf_we", i), rf_we, tbl[i].we);
      chk($sformatf("v%0d rf_wa", i), rf_wa, tbl[i].wa);
      chk($sformatf("v%0d rf_wd", i), rf_wd, tbl[i].wd);
    end
    ra1 = 5'd1; ra2 = 5'd0;
    #1;
    chk("x1 committed", rd1, 32'h1);
    chk("x0 reads zero", rd2, 32'h0);
    ra1 = 5'd2; ra2 = 5'd3;
    #1;
    chk("x2 committed", rd1, 32'hA);
    chk("x3 committed", rd2, 32'hB);
    ra1 = 5'd6;
    #1;
    chk("x6 committed", rd1, 32'h66);
    ra1 = 5'd5; ra2 = 5'd0;
    ex_valid = 1; ex_addr = 5'd5; ex_data = 32'h2;
    #1;
    chk("byp ex_ready", ex_ready, 1);
    tick();
    ex_valid = 0;
`ifdef REGFILE_WB_ARB_BYPASS_EN
    byp_exp = 32'h2;
`else
    byp_exp = 32'h0;
`endif
    chk("byp rf_we", rf_we, 1);
    chk("byp rd1 in flight", rd1, byp_exp);
    chk("byp rd2 x0", rd2, 32'h0);
    tick();
    chk("byp rd1 committed", rd1, 32'h2);
    ex_valid = 1; ex_addr = 5'd4; ex_data = 32'h7;
    #1;
    chk("rstmid ex_ready", ex_ready, 1);
    tick();
    chk("rstmid rf_we pending", rf_we, 1);
    rst = 1;
    ex_addr = 5'd2; ex_data = 32'hA;
    mem_valid = 1; mem_addr = 5'd3; mem_data = 32'hB;
    #1;
    chk("rstmid ex_ready low", ex_ready, 0);
    chk("rstmid mem_ready low", mem_ready, 0);
    tick();
    chk("rstmid rf_we cleared", rf_we, 0);
    ra1 = 5'd4;
    #1;
    chk("rstmid x4 unchanged", rd1, 32'h0);
    rst = 0;
    #1;
    chk("post rst ex wins", ex_ready, 1);
    chk("post rst mem waits", mem_ready, 0);
    tick();
    chk("post rst rf_wa", rf_wa, 5'd2);
    ex_valid = 0; mem_valid = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port (`we`/`wa`/`wd`) between two writeback requesters: the execute stage (EX) and the load/memory stage (MEM).
- Round-robin arbitration with valid/ready handshakes.
- A registered write stage drives the `reg_file` write port, so writes to x0 are suppressed at this point.
- An optional read bypass forwards the in-flight write onto the read data.

## Interface
- `DWIDTH`, 32, data width of the register file.
- `AWIDTH`, 5, register address width (32 registers).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  when high, no grant is issued (both readies low).
- `ex_valid`  in  1  EX writeback request.
- `ex_ready`  out  1  EX request accepted this cycle.
- `ex_addr`  in  AWIDTH  EX destination register.
- `ex_data`  in  DWIDTH  EX writeback data.
- `mem_valid`  in  1  MEM writeback request.
- `mem_ready`  out  1  MEM request accepted this cycle.
- `mem_addr`  in  AWIDTH  MEM destination register.
- `mem_data`  in  DWIDTH  MEM writeback data.
- `rf_we`  out  1  registered write enable to `reg_file` `we`.
- `rf_wa`  out  AWIDTH  registered write address to `reg_file` `wa`.
- `rf_wd`  out  DWIDTH  registered write data to `reg_file` `wd`.
- `ra1`, `ra2`  in  AWIDTH  read addresses, also driven to `reg_file`.
- `rf_rd1`, `rf_rd2`  in  DWIDTH  raw read data from `reg_file`.
- `rd1`, `rd2`  out  DWIDTH  read data delivered to the datapath.

## Operation
Priority pointer FSM, two states:
- **PRI_EX**: EX wins when both requesters are valid.
- **PRI_MEM**: MEM wins when both requesters are valid.
- Reset state is PRI_EX.

Grant rules (combinational, with `stall` low and `rst` low):
- Only one requester valid: that requester is granted.
- Both valid: the pointer's owner is granted.
- Neither valid: no grant.
- `ex_ready` = EX granted; `mem_ready` = MEM granted. The readies are never high simultaneously.

Pointer update:
- On a grant to EX, the pointer moves to PRI_MEM.
- On a grant to MEM, the pointer moves to PRI_EX.
- With no grant, the pointer holds.

Write stage, updated every clock edge:
- `rf_we` <= grant & (granted address != 0).
- `rf_wa` <= granted address.
- `rf_wd` <= granted data.
- With no grant, `rf_we` <= 0; `rf_wa` and `rf_wd` hold.

x0 handling: a write request to x0 is granted normally (handshake completes, pointer advances), but `rf_we` stays 0.

`stall` effects: forces both readies to 0 and holds the pointer. A write already registered in the write stage still drains on the next edge.

## Timing
- Handshake: a transfer occurs at edge N when valid & ready are both high during cycle N-1 → N.
  - Requesters hold addr/data stable until ready.
  - Ready depends combinationally on the valids, `stall` and the pointer only.
- Latency:
  - Accept at edge N → `rf_we`/`rf_wa`/`rf_wd` valid during cycle N..N+1.
  - `reg_file` updates at edge N+1.
  - Raw `rf_rd*` reflects the new value after edge N+1.
- Throughput: one write per cycle; sustained alternation when both requesters stay valid.
- Reset values: `rf_we`=0, `rf_wa`=0, `rf_wd`=0, pointer=PRI_EX.
  - `ex_ready` and `mem_ready` are 0 while `rst` is high.
- Reset mid-operation: a registered write not yet committed is discarded (`rf_we` cleared at the reset edge). Requesters must re-present.

## Configuration
Macro `REGFILE_WB_ARB_BYPASS_EN`:
- **Defined**:
  - `rd1` = `rf_wd` when `rf_we` & (`rf_wa` == `ra1`); otherwise `rd1` = `rf_rd1`. `rd2` follows the same rule with `ra2`.
  - Because `rf_we` is never set for x0, a read of x0 always returns `rf_rd*`.
  - Adds one comparator and one mux per read port.
- **Undefined**: `rd1` = `rf_rd1` and `rd2` = `rf_rd2` (pure passthrough).
- Ports are identical in both builds.

## Structure
- Shared package `regfile_pkg`:
  - `DWIDTH`/`AWIDTH` defaults.
  - Register-address typedef.
  - Pointer enum `pri_e {PRI_EX, PRI_MEM}`.
  - Constant `REG_ZERO = 0`.
- Sub-module `rf_bypass_mux`: one read port's compare-and-select, instantiated twice.
  - Under the macro it implements the bypass; otherwise it is a passthrough.
- Arbiter, pointer FSM and write stage live in the top module.

## Test plan
1. Reset for 2 cycles, EX requests (x1, 0x1) → `ex_ready` high the first cycle after reset; next cycle `rf_we`=1, `rf_wa`=1, `rf_wd`=0x1; `reg_file` x1=0x1 one edge later.
2. EX (x2, 0xA) and MEM (x3, 0xB) both valid for 4 cycles, pointer PRI_EX → grants EX, MEM, EX, MEM; `rf_wa` sequence 2, 3, 2, 3.
3. MEM requests (x0, 0xFFFF) alone → `mem_ready`=1; next cycle `rf_we`=0; x0 reads 0; pointer = PRI_EX.
4. `stall` high with both requesters valid for 3 cycles → both readies 0, `rf_we`=0, pointer unchanged; on release, the pointer owner is granted.
5. With the macro defined, write (x5, 0x2) accepted, `ra1`=5 during the `rf_we` cycle → `rd1`=0x2 while `rf_rd1` still shows the old value. Without the macro → `rd1`=`rf_rd1`.
6. Accept (x4, 0x7), assert `rst` on the following edge → `rf_we`=0 after that edge, x4 unchanged, pointer=PRI_EX.
